fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional misaligned-redirect checking is enabled by defining FETCH_CTRL_ALIGN_CHK_EN.
package fetch_ctrl_pkg;

    localparam int          INST_W           = 32;
    localparam int          ADDR_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with redirect and hold-until-consumed.
// Define FETCH_CTRL_ALIGN_CHK_EN to trap misaligned redirects into a sticky FAULT state.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic                inst_valid,
    output logic [INST_W-1:0]   inst,
    output logic [ADDR_W-1:0]   inst_pc,
    input  logic                inst_ready,
    output logic                fetch_fault
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;
    logic                imem_req_q, imem_req_d;
    logic                fault_q, fault_d;

    logic [ADDR_W-1:0]   redirect_tgt;
    logic                redirect_bad;
    logic                redirect_live;

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = is_misaligned(redirect_pc);
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign redirect_bad        = 1'b0;
`endif

    // Redirects are honoured only in the four active states.
    assign redirect_live = redirect_valid &&
                           (state_q == ST_REQ  || state_q == ST_WAIT ||
                            state_q == ST_HOLD || state_q == ST_DRAIN);

    always_comb begin
        // NOTE: every next-state variable takes its current value first so no path infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        fault_d      = fault_q;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_REQ;
                imem_req_d = 1'b1;
            end

            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_gnt) begin
                        state_d    = ST_DRAIN;
                        imem_req_d = 1'b0;
                    end
                end else if (imem_gnt) begin
                    state_d    = ST_WAIT;
                    imem_req_d = 1'b0;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_rvalid) begin
                        state_d    = ST_REQ;
                        imem_req_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_rvalid) begin
                    state_d      = ST_HOLD;
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d         = redirect_tgt;
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                    imem_req_d   = 1'b1;
                end else if (inst_ready) begin
                    pc_d         = pc_q + PC_STEP;
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                    imem_req_d   = 1'b1;
                end
            end

            ST_DRAIN: begin
                // A redirect here only retargets pc; the orphaned response still has to land.
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_rvalid) begin
                    state_d    = ST_REQ;
                    imem_req_d = 1'b1;
                end
            end

            ST_FAULT: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
            end

            default: begin
                state_d      = ST_IDLE;
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase

        if (redirect_live && redirect_bad) begin
            state_d      = ST_FAULT;
            pc_d         = pc_q;
            fault_d      = 1'b1;
            imem_req_d   = 1'b0;
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_req_q ? pc_q : '0;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_fault = fault_q;

endmodule
